// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: two debounced buttons drive a
// four-state run/pause/lap FSM that steers the counter datapath.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lc,
  input  logic       en_100hz,
  output logic       run,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      w_raw;
  logic [1:0]      r_sync0;
  logic [1:0]      r_sync1;
  logic [1:0]      r_db;
  logic [1:0]      r_db_q;
  logic [DB_W-1:0] r_cnt [2];
  logic            w_ss_p;
  logic            w_lc_p;

  state_t r_state;
  state_t w_state_n;
  logic   r_run;
  logic   r_frz;
  logic   r_clr;
  logic   w_clr_n;

  assign w_raw = {btn_lc, btn_ss};

  // Counter runs only while the synced level disagrees with the
  // debounced one; any return to agreement restarts the qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      r_db_q  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_db[i]  <= r_sync1[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_ss_p = r_db[0] & ~r_db_q[0];
  assign w_lc_p = r_db[1] & ~r_db_q[1];

  always_comb begin
    w_state_n = r_state;
    w_clr_n   = r_clr & ~en_100hz;
    case (r_state)
      S_IDLE: begin
        if (w_ss_p) begin
          if (!r_clr) w_state_n = S_RUN;
        end else if (w_lc_p) begin
          w_clr_n = 1'b1;
        end
      end
      S_RUN: begin
        if (w_ss_p)      w_state_n = S_PAUSE;
        else if (w_lc_p) w_state_n = S_LAP;
      end
      S_LAP: begin
        if (w_ss_p)      w_state_n = S_PAUSE;
        else if (w_lc_p) w_state_n = S_RUN;
      end
      S_PAUSE: begin
        if (w_ss_p) begin
          w_state_n = S_RUN;
        end else if (w_lc_p) begin
          w_state_n = S_IDLE;
          w_clr_n   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_frz   <= 1'b0;
      r_clr   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_run   <= (w_state_n == S_RUN) || (w_state_n == S_LAP);
      r_frz   <= (w_state_n == S_LAP);
      r_clr   <= w_clr_n;
    end
  end

  assign state  = r_state;
  assign run    = r_run;
  assign freeze = r_frz;
  assign clear  = r_clr;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table plus random button
// traffic compared against a behavioural model.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lc;
  logic       en_100hz;
  logic       run;
  logic       clear;
  logic       freeze;
  logic [1:0] state;

  int n_pass;
  int n_total;

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_lc   (btn_lc),
    .en_100hz (en_100hz),
    .run      (run),
    .clear    (clear),
    .freeze   (freeze),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a debounced level flips once the last four
  // synchronized samples (raw delayed two clocks) all disagree with it;
  // a 0->1 flip becomes a press seen by the FSM on the next edge.
  int m_st;
  bit m_clr;
  bit m_db    [2];
  bit m_pend  [2];
  bit m_raw_h [2][2];
  bit m_syn_h [2][4];
  bit m_ssp, m_lcp, m_nclr, m_diff, m_raw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st  = 0;
      m_clr = 1'b1;
      for (int b = 0; b < 2; b++) begin
        m_db[b]   = 1'b0;
        m_pend[b] = 1'b0;
        for (int j = 0; j < 2; j++) m_raw_h[b][j] = 1'b0;
        for (int j = 0; j < 4; j++) m_syn_h[b][j] = 1'b0;
      end
    end else begin
      m_ssp  = m_pend[0];
      m_lcp  = m_pend[1];
      m_nclr = m_clr && !en_100hz;
      case (m_st)
        0: if (m_ssp) begin
             if (!m_clr) m_st = 1;
           end else if (m_lcp) m_nclr = 1'b1;
        1: if (m_ssp) m_st = 2; else if (m_lcp) m_st = 3;
        3: if (m_ssp) m_st = 2; else if (m_lcp) m_st = 1;
        default: if (m_ssp) m_st = 1;
           else if (m_lcp) begin m_st = 0; m_nclr = 1'b1; end
      endcase
      m_clr = m_nclr;
      for (int b = 0; b < 2; b++) begin
        m_raw = (b == 0) ? btn_ss : btn_lc;
        for (int j = 3; j > 0; j--) m_syn_h[b][j] = m_syn_h[b][j-1];
        m_syn_h[b][0] = m_raw_h[b][1];
        m_diff = 1'b1;
        for (int j = 0; j < 4; j++)
          if (m_syn_h[b][j] == m_db[b]) m_diff = 1'b0;
        m_pend[b] = 1'b0;
        if (m_diff) begin
          m_db[b]   = !m_db[b];
          m_pend[b] = m_db[b];
        end
        m_raw_h[b][1] = m_raw_h[b][0];
        m_raw_h[b][0] = m_raw;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all(input string nm, input int st, input int r,
                         input int f, input int c);
    chk({nm, "_state"},  int'(state),  st);
    chk({nm, "_run"},    int'(run),    r);
    chk({nm, "_freeze"}, int'(freeze), f);
    chk({nm, "_clear"},  int'(clear),  c);
  endtask

  task automatic press(input bit ss, input bit lc,
                       input int prev, input int nxt, input string nm);
    btn_ss = ss;
    btn_lc = lc;
    cyc(6);
    chk({nm, "_lat_pre"}, int'(state), prev);
    cyc(1);
    chk({nm, "_lat_post"}, int'(state), nxt);
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    cyc(8);
  endtask

  task automatic tick();
    en_100hz = 1'b1;
    cyc(1);
    en_100hz = 1'b0;
    cyc(1);
  endtask

  typedef struct {
    bit         ss;
    bit         lc;
    bit         en;
    logic [1:0] st;
    bit         run;
    bit         frz;
    bit         clr;
  } vec_t;

  vec_t tbl [15];
  int   prev;
  int   hold [2];
  bit   lvl  [2];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0};

    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    btn_ss   = 1'b0;
    btn_lc   = 1'b0;
    en_100hz = 1'b0;
    #1;
    chk_all("reset", 0, 0, 0, 1);
    cyc(3);
    rst = 1'b0;
    cyc(5);
    chk("clear_held", int'(clear), 1);
    en_100hz = 1'b1;
    #1;
    chk("clear_tick_cycle", int'(clear), 1);
    cyc(1);
    en_100hz = 1'b0;
    chk_all("clear_released", 0, 0, 0, 0);
    cyc(4);

    btn_ss = 1'b1;
    cyc(3);
    btn_ss = 1'b0;
    cyc(10);
    chk_all("glitch", 0, 0, 0, 0);

    prev = 0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].en) tick();
      else press(tbl[i].ss, tbl[i].lc, prev, int'(tbl[i].st),
                 $sformatf("vec%0d", i));
      chk_all($sformatf("vec%0d", i), int'(tbl[i].st),
              int'(tbl[i].run), int'(tbl[i].frz), int'(tbl[i].clr));
      prev = int'(tbl[i].st);
    end

    btn_ss = 1'b1;
    cyc(4);
    #2;
    rst = 1'b1;
    #1;
    chk_all("lap_rst", 0, 0, 0, 1);
    btn_ss = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk_all("post_rst", 0, 0, 0, 1);
    tick();
    cyc(10);
    chk_all("post_rst_tick", 0, 0, 0, 0);

    hold[0] = 0;
    hold[1] = 0;
    lvl[0]  = 1'b0;
    lvl[1]  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rand_state",  int'(state),  m_st);
      chk("rand_run",    int'(run),    int'(m_st == 1 || m_st == 3));
      chk("rand_freeze", int'(freeze), int'(m_st == 3));
      chk("rand_clear",  int'(clear),  int'(m_clr));
      chk("rand_excl",   int'(clear && run), 0);
      for (int b = 0; b < 2; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 10));
        end
        hold[b]--;
      end
      btn_ss   = lvl[0];
      btn_lc   = lvl[1];
      en_100hz = ($urandom_range(0, 7) == 0);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
